// File: rtl/nou_noc_pkg.sv
// Shared NOU/NoC definitions: flit layout {tid, type, data} used by both the
// inject-side arbiter and the egress interface that unpacks flits.
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package nou_noc_pkg;

  localparam int TID_W  = `TID_WIDTH;
  localparam int TYPE_W = `TYPE_WIDTH;
  localparam int DAT_W  = `DAT_DAT_WIDTH;
  localparam int FLIT_W = TID_W + TYPE_W + DAT_W;

  localparam int DATA_LSB = 0;
  localparam int TYPE_LSB = DAT_W;
  localparam int TID_LSB  = DAT_W + TYPE_W;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [TYPE_W-1:0] typ;
    logic [DAT_W-1:0]  data;
  } flit_t;

  function automatic flit_t pack_flit(input logic [TID_W-1:0] tid,
                                      input logic [TYPE_W-1:0] typ,
                                      input logic [DAT_W-1:0] data);
    flit_t f;
    f.tid  = tid;
    f.typ  = typ;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/nou_rr_arbiter.sv
// Round-robin arbiter: searches requests starting at r_ptr; the pointer moves
// past the winner only when the grant is consumed (advance).
module nou_rr_arbiter
  import nou_noc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_idx;
  logic [IW-1:0] w_id;
  logic          w_found;

  // Rotating priority search, wrapping modulo N
  always_comb begin
    w_found = 1'b0;
    w_id    = {IW{1'b0}};
    w_idx   = {(IW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(N)) begin
        w_idx = w_idx - (IW+1)'(N);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_id    = w_idx[IW-1:0];
      end else begin
        w_found = w_found;
      end
    end
    if (w_found) begin
      gnt = {{(N-1){1'b0}}, 1'b1} << w_id;
    end else begin
      gnt = {N{1'b0}};
    end
    gnt_id = w_id;
  end

  // Pointer update: only a completed transfer rotates priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {IW{1'b0}};
    end else if (advance) begin
      if (w_id == IW'(N-1)) begin
        r_ptr <= {IW{1'b0}};
      end else begin
        r_ptr <= w_id + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/nou_in_arbiter_unit.sv
// NOU injection arbiter: round-robin shares one credit-flow-controlled router
// input among NUM_REQ valid/ready requesters, registering one flit per transfer.
module nou_in_arbiter_unit
  import nou_noc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = `DATA_WIDTH,
  parameter int DAT_WIDTH = `DAT_DAT_WIDTH,
  parameter int CREDITS   = 4,
  parameter int CW        = $clog2(CREDITS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0][TID_W-1:0]     nou_noiu_tid,
  input  logic [NUM_REQ-1:0][TYPE_W-1:0]    nou_noiu_type,
  input  logic [NUM_REQ-1:0][DAT_WIDTH-1:0] nou_noiu_data,
  input  logic [NUM_REQ-1:0]                nou_noiu_valid,
  output logic [NUM_REQ-1:0]                noiu_nou_ready,
  output logic [WIDTH-1:0]                  noiu_router_data,
  output logic                              noiu_router_valid,
  input  logic                              router_noiu_yummy,
  output logic [CW-1:0]                     noiu_credit_cnt,
  output logic                              noiu_credit_err
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_id;
  logic               w_can_send;
  logic               w_transfer;
  logic [WIDTH-1:0]   w_flit;

  logic [CW-1:0]      r_credit_cnt;
  logic               r_credit_err;
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;

  nou_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (nou_noiu_valid),
    .advance (w_transfer),
    .gnt     (w_gnt),
    .gnt_id  (w_gnt_id)
  );

  // Ready depends only on registered credits, never on this cycle's yummy
  always_comb begin
    w_can_send     = (r_credit_cnt != CW'(0)) && !rst;
    noiu_nou_ready = w_gnt & {NUM_REQ{w_can_send}};
    w_transfer     = |(nou_noiu_valid & noiu_nou_ready);
    w_flit         = {nou_noiu_tid[w_gnt_id], nou_noiu_type[w_gnt_id],
                      nou_noiu_data[w_gnt_id]};
  end

  // Output flit register and credit bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data       <= {WIDTH{1'b0}};
      r_credit_cnt <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      r_valid <= w_transfer;
      if (w_transfer) begin
        r_data <= w_flit;
      end else begin
        r_data <= r_data;
      end
      case ({w_transfer, router_noiu_yummy})
        2'b10: r_credit_cnt <= r_credit_cnt - CW'(1);
        2'b01: begin
          if (r_credit_cnt == CW'(CREDITS)) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + CW'(1);
          end
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  assign noiu_router_valid = r_valid;
  assign noiu_router_data  = r_data;
  assign noiu_credit_cnt   = r_credit_cnt;
  assign noiu_credit_err   = r_credit_err;

endmodule

// File: tb/tb_nou_in_arbiter_unit.sv
// Self-checking bench: directed vector table, stall/reset and fairness
// sequences, then randomized traffic against a behavioural model.
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_nou_in_arbiter_unit;
  localparam int N  = 4;
  localparam int CR = 4;
  localparam int CW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][3:0]    tid;
  logic [N-1:0][3:0]    typ;
  logic [N-1:0][7:0]    dat;
  logic [N-1:0]         vld;
  logic [N-1:0]         rdy;
  logic [15:0]          r_data;
  logic                 r_valid;
  logic                 yummy;
  logic [CW-1:0]        cnt;
  logic                 err;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int          m_cnt, m_ptr, m_err, m_rv;
  logic [15:0] m_data;
  int          last_winner;

  nou_in_arbiter_unit #(.NUM_REQ(N), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst),
    .nou_noiu_tid(tid), .nou_noiu_type(typ), .nou_noiu_data(dat),
    .nou_noiu_valid(vld), .noiu_nou_ready(rdy),
    .noiu_router_data(r_data), .noiu_router_valid(r_valid),
    .router_noiu_yummy(yummy), .noiu_credit_cnt(cnt), .noiu_credit_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // one cycle: drive, check ready vs model, clock, update model, check outputs
  task automatic cycle_m(input logic r, input logic [N-1:0] v, input logic y);
    int w;
    logic [N-1:0] exp_rdy;
    rst = r; vld = v; yummy = y;
    #1;
    w = winner(v);
    exp_rdy = '0;
    if (!r && m_cnt > 0 && w >= 0) exp_rdy[w] = 1'b1;
    chk("ready", 32'(rdy), 32'(exp_rdy));
    @(posedge clk); #1;
    last_winner = -1;
    if (r) begin
      m_cnt = CR; m_ptr = 0; m_err = 0; m_rv = 0; m_data = '0;
    end else begin
      m_rv = (exp_rdy != '0);
      if (m_rv) begin
        m_data = {tid[w], typ[w], dat[w]};
        m_ptr = (w + 1) % N;
        last_winner = w;
      end
      if (y && !m_rv && m_cnt == CR) m_err = 1;
      m_cnt = m_cnt - m_rv + int'(y);
      if (m_cnt > CR) m_cnt = CR;
    end
    chk("router_valid", 32'(r_valid), 32'(m_rv));
    if (m_rv) chk("router_data", 32'(r_data), 32'(m_data));
    chk("credit_cnt", 32'(cnt), 32'(m_cnt));
    chk("credit_err", 32'(err), 32'(m_err));
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        yum;
    logic [3:0]  rdy;
    logic        rv;
    logic        chk_data;
    logic [15:0] data;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic [3:0] v, logic y, logic [3:0] er,
                              logic rv, logic cd, logic [15:0] d, logic [2:0] c, logic e);
    vec_t t;
    t.rst = r; t.vld = v; t.yum = y; t.rdy = er; t.rv = rv;
    t.chk_data = cd; t.data = d; t.cnt = c; t.err = e;
    return t;
  endfunction

  initial begin
    logic [N-1:0] pend;
    logic [1:0]   yq;
    int           seq, budget, owed;
    logic         y;

    rst = 1'b1; vld = '0; yummy = 1'b0;
    tid = {4'd6, 4'd5, 4'd4, 4'd3};
    typ = {4'd4, 4'd3, 4'd2, 4'd1};
    dat = {8'hC3, 8'h33, 8'h5A, 8'hA5};

    //            rst  vld     y     rdy     rv    cd    data      cnt   err
    tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b0);
    tbl[1]  = mk(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h31A5, 3'd3, 1'b0);
    tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0);
    tbl[3]  = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd2, 1'b0);
    tbl[4]  = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd1, 1'b0);
    tbl[5]  = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd0, 1'b0);
    tbl[6]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    tbl[7]  = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0);
    tbl[8]  = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd0, 1'b0);
    tbl[9]  = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0);
    tbl[10] = mk(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd1, 1'b0);
    tbl[11] = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd0, 1'b0);
    tbl[12] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0);
    tbl[13] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);
    tbl[14] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0);
    tbl[15] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b0);
    tbl[16] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1);
    tbl[17] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1);
    tbl[18] = mk(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 16'h5333, 3'd3, 1'b1);
    tbl[19] = mk(1'b0, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b1, 16'h64C3, 3'd2, 1'b1);
    tbl[20] = mk(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h31A5, 3'd1, 1'b1);
    tbl[21] = mk(1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b0);
    tbl[22] = mk(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h425A, 3'd3, 1'b0);

    @(posedge clk); #1;
    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; vld = tbl[i].vld; yummy = tbl[i].yum;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rvalid", i), 32'(r_valid), 32'(tbl[i].rv));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_rdata", i), 32'(r_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    // stall req2 at zero credits, then a one-cycle reset
    m_cnt = CR; m_ptr = 0; m_err = 0; m_rv = 0; m_data = '0;
    cycle_m(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) cycle_m(1'b0, 4'b0100, 1'b0);
    chk("stall_cnt_zero", 32'(cnt), 32'd0);
    cycle_m(1'b1, 4'b0100, 1'b0);
    chk("rst_cnt", 32'(cnt), 32'd4);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    cycle_m(1'b0, 4'b0100, 1'b0);
    chk("post_rst_req2", 32'(last_winner), 32'd2);

    // fairness: all valid, yummy two cycles after each flit
    cycle_m(1'b1, 4'b0000, 1'b0);
    yq = 2'b00; seq = 0;
    for (int i = 0; i < 40; i++) begin
      cycle_m(1'b0, 4'b1111, yq[1]);
      chk("onehot", 32'($countones(rdy) <= 1), 32'd1);
      yq = {yq[0], r_valid};
      if (last_winner >= 0) begin
        chk("rr_order", 32'(last_winner), 32'(seq % N));
        seq++;
      end
    end
    chk("fair_progress", 32'(seq >= 20), 32'd1);

    // randomized traffic honouring valid-held-until-ready
    cycle_m(1'b1, 4'b0000, 1'b0);
    pend = '0;
    budget = 0;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1) begin
          pend[r] = 1'b1;
          tid[r] = 4'($urandom); typ[r] = 4'($urandom); dat[r] = 8'($urandom);
        end
      end
      owed = CR - m_cnt;
      y = (owed > 0 && $urandom_range(2, 0) != 0) || ($urandom_range(49, 0) == 0);
      cycle_m(($urandom_range(99, 0) == 0), pend, y);
      if (last_winner >= 0) pend[last_winner] = 1'b0;
      budget++;
    end
    chk("random_ran", 32'(budget), 32'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
